// File: rtl/mdu_iterative.sv
// Radix-2 shift-add multiply / restoring divide for RV32M; DONE WIDTH+2 edges after accept (divide special cases: 2 edges).
// Backpressure: READY low while busy, START ignored then; FLUSH aborts to idle and keeps the last result.
module mdu_iterative #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             MDU_START_i,
    input  logic             MDU_FLUSH_i,
    input  logic [2:0]       MDU_OP_i,
    input  logic [WIDTH-1:0] MDU_RS1_i,
    input  logic [WIDTH-1:0] MDU_RS2_i,
    output logic             MDU_READY_o,
    output logic             MDU_DONE_o,
    output logic [WIDTH-1:0] MDU_RD_o
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     b_reg;
    logic [2:0]           op_reg;
    logic                 q_neg, r_neg;

    logic                 accept, a_sgn, b_sgn, a_neg, b_neg;
    logic                 div_zero, div_ovf;
    logic [WIDTH-1:0]     a_abs, b_abs;
    logic [WIDTH:0]       mul_sum, div_r, div_d;
    logic [2*WIDTH-1:0]   prod_step, prod_neg;
    logic [WIDTH-1:0]     hi, lo, res;

    assign MDU_READY_o = (state == IDLE);
    assign accept      = MDU_START_i & MDU_READY_o & ~MDU_FLUSH_i;

    // Operand signedness: MULH/DIV/REM both signed, MULHSU only A; MUL is sign-agnostic in the low half.
    always_comb begin
        a_sgn    = (MDU_OP_i == 3'b001) | (MDU_OP_i == 3'b010) | (MDU_OP_i == 3'b100) | (MDU_OP_i == 3'b110);
        b_sgn    = (MDU_OP_i == 3'b001) | (MDU_OP_i == 3'b100) | (MDU_OP_i == 3'b110);
        a_neg    = a_sgn & MDU_RS1_i[WIDTH-1];
        b_neg    = b_sgn & MDU_RS2_i[WIDTH-1];
        a_abs    = a_neg ? -MDU_RS1_i : MDU_RS1_i;
        b_abs    = b_neg ? -MDU_RS2_i : MDU_RS2_i;
        div_zero = MDU_OP_i[2] & (MDU_RS2_i == '0);
        div_ovf  = MDU_OP_i[2] & ~MDU_OP_i[0]
                 & (MDU_RS1_i == {1'b1, {(WIDTH-1){1'b0}}}) & (MDU_RS2_i == '1);
    end

    // One iteration: prod holds {acc, multiplier} for MUL and {remainder, quotient} for DIV.
    always_comb begin
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, b_reg} : '0);
        div_r     = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
        div_d     = div_r - {1'b0, b_reg};
        prod_step = {mul_sum, prod[WIDTH-1:1]};
        if (op_reg[2]) begin
            if (!div_d[WIDTH]) prod_step = {div_d[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
            else               prod_step = {div_r[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        prod_neg = -prod;
        hi       = prod[2*WIDTH-1:WIDTH];
        lo       = prod[WIDTH-1:0];
        if (!op_reg[2]) begin
            res = (op_reg == 3'b000) ? (q_neg ? prod_neg[WIDTH-1:0] : lo)
                                     : (q_neg ? prod_neg[2*WIDTH-1:WIDTH] : hi);
        end else if (op_reg[1]) begin
            res = r_neg ? -hi : hi;
        end else begin
            res = q_neg ? -lo : lo;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (div_zero | div_ovf) ? FIX : CALC;
            CALC: if (cnt == CNT_W'(1)) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (MDU_FLUSH_i) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            prod       <= '0;
            b_reg      <= '0;
            op_reg     <= '0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            MDU_RD_o   <= '0;
            MDU_DONE_o <= 1'b0;
        end else begin
            MDU_DONE_o <= 1'b0;
            if (!MDU_FLUSH_i) begin
                case (state)
                    IDLE: if (accept) begin
                        op_reg <= MDU_OP_i;
                        b_reg  <= b_abs;
                        cnt    <= CNT_W'(WIDTH);
                        q_neg  <= a_neg ^ b_neg;
                        r_neg  <= a_neg;
                        prod   <= {{WIDTH{1'b0}}, a_abs};
                        // Special divides preload the final answer and skip sign correction.
                        if (div_zero) begin
                            prod  <= {MDU_RS1_i, {WIDTH{1'b1}}};
                            q_neg <= 1'b0;
                            r_neg <= 1'b0;
                        end else if (div_ovf) begin
                            prod  <= {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
                            q_neg <= 1'b0;
                            r_neg <= 1'b0;
                        end
                    end
                    CALC: begin
                        prod <= prod_step;
                        cnt  <= cnt - CNT_W'(1);
                    end
                    FIX: begin
                        MDU_RD_o   <= res;
                        MDU_DONE_o <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative at WIDTH=32 and WIDTH=16.
module tb_mdu_iterative;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start32 = 1'b0, flush32 = 1'b0;
    logic [2:0]  op32 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        ready32, done32;
    logic [31:0] rd32;
    logic        start16 = 1'b0, flush16 = 1'b0;
    logic [2:0]  op16 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        ready16, done16;
    logic [15:0] rd16;

    int total = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mdu_iterative #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .MDU_START_i(start32), .MDU_FLUSH_i(flush32),
        .MDU_OP_i(op32), .MDU_RS1_i(a32), .MDU_RS2_i(b32),
        .MDU_READY_o(ready32), .MDU_DONE_o(done32), .MDU_RD_o(rd32)
    );

    mdu_iterative #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .MDU_START_i(start16), .MDU_FLUSH_i(flush16),
        .MDU_OP_i(op16), .MDU_RS1_i(a16), .MDU_RS2_i(b16),
        .MDU_READY_o(ready16), .MDU_DONE_o(done16), .MDU_RD_o(rd16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, scramble operands after accept, wait for DONE and check latency/result/READY.
    task automatic run_op(input bit w16, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string tag);
        int  n;
        bit  seen;
        if (w16) begin op16 = op; a16 = a[15:0]; b16 = b[15:0]; start16 = 1'b1; end
        else     begin op32 = op; a32 = a;       b32 = b;       start32 = 1'b1; end
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0;
        start32 = 1'b0;
        a32 = $urandom; b32 = $urandom; a16 = 16'($urandom); b16 = 16'($urandom);
        chk({tag, " busy"}, {31'd0, w16 ? ready16 : ready32}, 32'd0);
        seen = 1'b0;
        n = 0;
        for (int i = 1; i <= 80 && !seen; i++) begin
            @(negedge clk);
            if (w16 ? done16 : done32) begin
                seen = 1'b1;
                n = i;
            end
        end
        chk({tag, " latency"}, seen ? n : 999, lat);
        chk({tag, " result"}, w16 ? {16'd0, rd16} : rd32, exp);
        chk({tag, " ready@done"}, {31'd0, w16 ? ready16 : ready32}, 32'd1);
    endtask

    initial begin
        int          dones;
        logic [31:0] old;

        repeat (2) @(negedge clk);
        chk("rst32 ready", {31'd0, ready32}, 32'd1);
        chk("rst32 done", {31'd0, done32}, 32'd0);
        chk("rst32 rd", rd32, 32'd0);
        chk("rst16 rd", {16'd0, rd16}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back: each op starts in the previous op's DONE cycle.
        run_op(0, 3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul32");
        run_op(0, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh32");
        run_op(0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu32");
        run_op(0, 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, "mulhsu32");
        run_op(0, 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, "div32");
        run_op(0, 3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, "rem32");
        run_op(0, 3'b101, 32'd100,      32'd7,        32'd14,       33, "divu32");
        run_op(0, 3'b111, 32'd100,      32'd7,        32'd2,        33, "remu32");
        run_op(0, 3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  "div0_32");
        run_op(0, 3'b110, 32'd5,        32'd0,        32'd5,        1,  "rem0_32");
        run_op(0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "divovf32");
        run_op(0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  "removf32");

        // Flush mid-DIVU: no DONE, READY next cycle, RD keeps the old value.
        old = rd32;
        op32 = 3'b101; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (9) @(negedge clk);
        flush32 = 1'b1;
        @(negedge clk);
        flush32 = 1'b0;
        chk("flush ready", {31'd0, ready32}, 32'd1);
        chk("flush done", {31'd0, done32}, 32'd0);
        chk("flush rd", rd32, old);
        dones = 0;
        repeat (40) begin @(negedge clk); if (done32) dones++; end
        chk("flush no done", dones, 0);
        run_op(0, 3'b000, 32'd3, 32'd5, 32'd15, 33, "mul_after_flush");

        // FLUSH and START together: start is dropped.
        @(negedge clk);
        flush32 = 1'b1; start32 = 1'b1; op32 = 3'b000; a32 = 32'd9; b32 = 32'd9;
        @(negedge clk);
        flush32 = 1'b0; start32 = 1'b0;
        chk("flush+start ready", {31'd0, ready32}, 32'd1);
        dones = 0;
        repeat (40) begin @(negedge clk); if (done32) dones++; end
        chk("flush+start no done", dones, 0);

        // START held while busy: exactly one DONE.
        op32 = 3'b011; a32 = 32'hFFFFFFFF; b32 = 32'hFFFFFFFF; start32 = 1'b1;
        dones = 0;
        repeat (80) begin
            @(negedge clk);
            if (done32) begin dones++; start32 = 1'b0; end
        end
        start32 = 1'b0;
        chk("held start dones", dones, 1);
        chk("held start rd", rd32, 32'hFFFFFFFE);

        // Asynchronous reset in the middle of CALC.
        op32 = 3'b000; a32 = 32'd11; b32 = 32'd13; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst ready", {31'd0, ready32}, 32'd1);
        chk("arst done", {31'd0, done32}, 32'd0);
        chk("arst rd", rd32, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(0, 3'b000, 32'd11, 32'd13, 32'd143, 33, "mul_after_rst");

        run_op(1, 3'b000, 32'd7,    32'hFFFD, 32'hFFEB, 17, "mul16");
        run_op(1, 3'b001, 32'h8000, 32'h8000, 32'h4000, 17, "mulh16");
        run_op(1, 3'b011, 32'hFFFF, 32'hFFFF, 32'hFFFE, 17, "mulhu16");
        run_op(1, 3'b010, 32'hFFFF, 32'd2,    32'hFFFF, 17, "mulhsu16");
        run_op(1, 3'b100, 32'hFFF9, 32'd2,    32'hFFFD, 17, "div16");
        run_op(1, 3'b110, 32'hFFF9, 32'd2,    32'hFFFF, 17, "rem16");
        run_op(1, 3'b101, 32'd100,  32'd7,    32'd14,   17, "divu16");
        run_op(1, 3'b111, 32'd100,  32'd7,    32'd2,    17, "remu16");
        run_op(1, 3'b100, 32'd5,    32'd0,    32'hFFFF, 1,  "div0_16");
        run_op(1, 3'b110, 32'd5,    32'd0,    32'd5,    1,  "rem0_16");
        run_op(1, 3'b100, 32'h8000, 32'hFFFF, 32'h8000, 1,  "divovf16");
        run_op(1, 3'b110, 32'h8000, 32'hFFFF, 32'd0,    1,  "removf16");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
